// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a held load/store request, waits WAIT_STATES
// cycles, performs the access on a word array or MMIO pair, then pulses ready.
module dmem_responder #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_OUT_ADDR = 16'hFF00,
  parameter logic [15:0] IO_IN_ADDR  = 16'hFF01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] io_in,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic [15:0] io_out,
  output logic        err,
  output logic [1:0]  state
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      cur, nxt;
  logic [3:0]  cnt;
  logic [15:0] addr_q, wdata_q;
  logic        rd_q, wr_q;
  logic [15:0] mem [DEPTH];

  logic        accept, access;
  logic [15:0] a_addr, a_wdata;
  logic        a_rd, a_wr;
  logic        in_array, is_out, is_in;
  logic [AW-1:0] idx;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (mem_read | mem_write) nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request inputs are used instead of the captured copies.
  always_comb begin
    accept   = (cur == S_IDLE) && (mem_read | mem_write);
    access   = (accept && (WAIT_STATES == 0)) || ((cur == S_WAIT) && (cnt == 4'd0));
    a_addr   = (cur == S_IDLE) ? addr      : addr_q;
    a_wdata  = (cur == S_IDLE) ? wdata     : wdata_q;
    a_rd     = (cur == S_IDLE) ? mem_read  : rd_q;
    a_wr     = (cur == S_IDLE) ? mem_write : wr_q;
    in_array = a_addr < 16'(DEPTH);
    is_out   = a_addr == IO_OUT_ADDR;
    is_in    = a_addr == IO_IN_ADDR;
    idx      = a_addr[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 16'h0;
      io_out  <= 16'h0;
      err     <= 1'b0;
    end else begin
      ready <= (nxt == S_RESP);
      busy  <= (nxt != S_IDLE);
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        cnt     <= CNT_INIT;
      end else if ((cur == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        if (a_rd && a_wr) begin
          err <= 1'b1;
        end else if (a_rd) begin
          if (in_array)    rdata <= mem[idx];
          else if (is_out) rdata <= io_out;
          else if (is_in)  rdata <= io_in;
          else begin
            rdata <= 16'h0;
            err   <= 1'b1;
          end
        end else if (a_wr && !in_array) begin
          if (is_out) io_out <= a_wdata;
          else        err    <= 1'b1;
        end
      end
    end
  end

  // Array storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && access && a_wr && !a_rd && in_array) mem[idx] <= a_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: unit 0 has two wait states, unit 1 has none.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [15:0] addr      [2];
  logic [15:0] wdata     [2];
  logic [15:0] io_in     [2];
  logic [15:0] rdata     [2];
  logic        ready     [2];
  logic        busy      [2];
  logic [15:0] io_out    [2];
  logic        err       [2];
  logic [1:0]  state     [2];

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int          u;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] io;
    int          lat;
    logic [15:0] exp_rdata;
    logic [15:0] exp_io_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  dmem_responder #(.WAIT_STATES(2)) dut0 (
    .clk(clk), .reset(reset), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .addr(addr[0]), .wdata(wdata[0]), .io_in(io_in[0]), .rdata(rdata[0]),
    .ready(ready[0]), .busy(busy[0]), .io_out(io_out[0]), .err(err[0]), .state(state[0])
  );

  dmem_responder #(.WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .addr(addr[1]), .wdata(wdata[1]), .io_in(io_in[1]), .rdata(rdata[1]),
    .ready(ready[1]), .busy(busy[1]), .io_out(io_out[1]), .err(err[1]), .state(state[1])
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Raise a request, wait (bounded) for ready, drop the request in the ready cycle.
  task automatic txn(input int u, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, output int lat, output int busy_n);
    @(negedge clk);
    mem_read[u] = rd; mem_write[u] = wr; addr[u] = a; wdata[u] = d;
    @(posedge clk);
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy[u]) busy_n++;
    end while (!ready[u] && lat < 40);
    mem_read[u] = 1'b0; mem_write[u] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat, busy_n;
    io_in[v.u] = v.io;
    exp_q.push_back(v.exp_rdata);
    txn(v.u, v.rd, v.wr, v.a, v.d, lat, busy_n);
    chk({name, "_ready"},  16'(ready[v.u]), 16'd1);
    chk({name, "_lat"},    16'(lat), 16'(v.lat));
    chk({name, "_busy"},   16'(busy_n), 16'(v.lat));
    chk({name, "_rdata"},  rdata[v.u], exp_q.pop_front());
    chk({name, "_io_out"}, io_out[v.u], v.exp_io_out);
    chk({name, "_err"},    16'(err[v.u]), 16'(v.exp_err));
    @(negedge clk);
    chk({name, "_pulse"},  16'(ready[v.u]), 16'd0);
    chk({name, "_idle"},   16'(busy[v.u]), 16'd0);
  endtask

  initial begin
    int n;
    logic seen;
    vec_t v;

    // u  rd    wr    addr       wdata      io_in     lat rdata    io_out   err
    vecs[0]  = '{0, 1'b0, 1'b1, 16'h0003, 16'hA5A5, 16'h0000, 3, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 3, 16'hA5A5, 16'h0000, 1'b0};
    vecs[2]  = '{0, 1'b0, 1'b1, 16'hFF00, 16'hBEEF, 16'h0000, 3, 16'hA5A5, 16'hBEEF, 1'b0};
    vecs[3]  = '{0, 1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 3, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[4]  = '{0, 1'b1, 1'b0, 16'hFF01, 16'h0000, 16'h0C0C, 3, 16'h0C0C, 16'hBEEF, 1'b0};
    vecs[5]  = '{0, 1'b0, 1'b1, 16'h0007, 16'h1111, 16'h0000, 3, 16'h0C0C, 16'hBEEF, 1'b0};
    vecs[6]  = '{0, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000, 3, 16'h1111, 16'hBEEF, 1'b0};
    vecs[7]  = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 3, 16'h0000, 16'hBEEF, 1'b1};
    vecs[8]  = '{0, 1'b1, 1'b1, 16'h0003, 16'h7777, 16'h0000, 3, 16'h0000, 16'hBEEF, 1'b1};
    vecs[9]  = '{0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 3, 16'hA5A5, 16'hBEEF, 1'b1};
    vecs[10] = '{1, 1'b0, 1'b1, 16'h0000, 16'h1234, 16'h0000, 1, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1234, 16'h0000, 1'b0};
    vecs[12] = '{1, 1'b1, 1'b0, 16'h000F, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{1, 1'b0, 1'b1, 16'hFF01, 16'h5678, 16'h0000, 1, 16'h0000, 16'h0000, 1'b1};

    // vecs[12] reads an unwritten word: seed it first so the value is known
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      mem_read[u] = 1'b0; mem_write[u] = 1'b0;
      addr[u] = 16'h0; wdata[u] = 16'h0; io_in[u] = 16'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst%0d_rdata", u),  rdata[u], 16'h0);
      chk($sformatf("rst%0d_ready", u),  16'(ready[u]), 16'h0);
      chk($sformatf("rst%0d_busy", u),   16'(busy[u]), 16'h0);
      chk($sformatf("rst%0d_io_out", u), io_out[u], 16'h0);
      chk($sformatf("rst%0d_err", u),    16'(err[u]), 16'h0);
    end
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (i == 12) begin
        v = '{1, 1'b0, 1'b1, 16'h000F, 16'h0000, 16'h0000, 1, 16'h1234, 16'h0000, 1'b0};
        run_vec(v, "seed15");
      end
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Held read: second transaction accepted in the IDLE cycle after RESP;
    // addr changed mid-WAIT only affects the second one.
    @(negedge clk);
    mem_read[0] = 1'b1; addr[0] = 16'h0003; wdata[0] = 16'h0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    addr[0] = 16'h0007; wdata[0] = 16'h9999;
    n = 0;
    while (!ready[0] && n < 20) begin @(negedge clk); n++; end
    chk("hold1_lat",   16'(n), 16'd1);
    chk("hold1_rdata", rdata[0], 16'hA5A5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("hold_gap_busy", 16'(busy[0]), 16'd0);
    end while (!ready[0] && n < 20);
    mem_read[0] = 1'b0;
    chk("hold2_spacing", 16'(n), 16'd4);
    chk("hold2_rdata",   rdata[0], 16'h1111);
    @(negedge clk);
    chk("hold2_pulse", 16'(ready[0]), 16'd0);

    // Store with addr/wdata toggled mid-WAIT.
    mem_write[0] = 1'b1; addr[0] = 16'h0009; wdata[0] = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    addr[0] = 16'h000A; wdata[0] = 16'h3333;
    n = 0;
    while (!ready[0] && n < 20) begin @(negedge clk); n++; end
    mem_write[0] = 1'b0;
    chk("toggle_wr_ready", 16'(ready[0]), 16'd1);
    v = '{0, 1'b1, 1'b0, 16'h0009, 16'h0000, 16'h0000, 3, 16'h2222, 16'hBEEF, 1'b1};
    run_vec(v, "toggle_rd");

    // Reset mid-transaction aborts the store.
    v = '{0, 1'b0, 1'b1, 16'h0005, 16'h5555, 16'h0000, 3, 16'h2222, 16'hBEEF, 1'b1};
    run_vec(v, "abort_pre");
    @(negedge clk);
    mem_write[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_write[0] = 1'b0;
    chk("abort_rdata",  rdata[0], 16'h0);
    chk("abort_ready",  16'(ready[0]), 16'h0);
    chk("abort_busy",   16'(busy[0]), 16'h0);
    chk("abort_io_out", io_out[0], 16'h0);
    chk("abort_err",    16'(err[0]), 16'h0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready[0]) seen = 1'b1;
    end
    chk("abort_no_ready", 16'(seen), 16'd0);
    v = '{0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 3, 16'h5555, 16'h0000, 1'b0};
    run_vec(v, "abort_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 16-bit RISC processor's load/store port. It accepts a held `mem_read`/`mem_write` request, inserts a programmable number of wait states, and performs the access on an internal word array or on a memory-mapped I/O register pair. It completes each transaction with a one-cycle `ready` pulse. It sits between the processor datapath and on-chip data storage, and gives the core a real request/acknowledge memory interface in place of a zero-latency array.

## Interface
- `DEPTH`, 16: number of 16-bit words in the internal array; must be a power of two, 2..256.
- `WAIT_STATES`, 2: cycles spent in WAIT before the response; range 0..15.
- `IO_OUT_ADDR`, 16'hFF00: address of the write/readback output register.
- `IO_IN_ADDR`, 16'hFF01: address of the read-only input port.

- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `mem_read` in 1: load request; held by the requester until `ready`.
- `mem_write` in 1: store request; held by the requester until `ready`.
- `addr` in 16: word address; sampled at acceptance.
- `wdata` in 16: store data; sampled at acceptance.
- `io_in` in 16: external input, sampled at response time.
- `rdata` out 16: load data; valid while `ready` is high and held until the next load response.
- `ready` out 1: one-cycle transaction-complete pulse.
- `busy` out 1: high from the cycle after acceptance through the RESP cycle.
- `io_out` out 16: memory-mapped output register.
- `err` out 1: sticky error flag.

## Operation
- Address decode, with AW = log2(DEPTH):
  - `addr` < DEPTH selects the array at index `addr[AW-1:0]`.
  - `addr` == IO_OUT_ADDR selects the `io_out` register.
  - `addr` == IO_IN_ADDR selects `io_in`. A store to this address is dropped and sets `err`.
  - Any other address is out of range.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if (`mem_read` | `mem_write`) at a rising edge, capture `addr`, `wdata` and the op. Go to WAIT, or go directly to RESP when WAIT_STATES=0. Load the wait counter with WAIT_STATES-1.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to RESP on the next edge and perform the access on that same edge.
  - RESP: `ready`=1 for exactly one cycle, then return to IDLE.
- Access rules:
  - Load from the array or from `io_out`: the stored value goes to `rdata`.
  - Load from IO_IN_ADDR: `io_in` is sampled on the access edge.
  - Load from an out-of-range address: `rdata` = 16'h0000 and `err` is set.
  - Store to the array or to `io_out`: the write commits on the access edge.
  - Store to an out-of-range address or to IO_IN_ADDR: dropped, `err` is set.
- `mem_read` and `mem_write` both high at acceptance: no access, `rdata` unchanged, `err` set. `ready` still pulses on schedule.
- Request signals are ignored outside IDLE. Changes to `addr`/`wdata` after acceptance have no effect.
- If a request is still high in the IDLE cycle after RESP, it is accepted as a new transaction. The requester must drop it in the cycle `ready` is seen.
- Reset is synchronous and takes priority over everything.
  - Outputs: `rdata`=0, `ready`=0, `busy`=0, `io_out`=0, `err`=0. FSM goes to IDLE and the counter clears.
  - Array contents are not reset.
  - Reset asserted before the access edge aborts the transaction with no write committed and no `ready`.
- `err` is cleared only by reset.

## Timing
- Acceptance edge T0 (FSM in IDLE, request high). Let N = max(WAIT_STATES, 1).
  - `busy` is high from T0+1 through the RESP cycle.
  - The access edge is T0+N, or T0 when WAIT_STATES=0.
  - `ready` is high during the cycle following the access edge.
- Load-to-use latency is WAIT_STATES+1 cycles; WAIT_STATES=0 gives 1 cycle.
- Minimum spacing between transaction starts is WAIT_STATES+2 cycles, including the IDLE cycle.
- `rdata`, `ready`, `busy`, `io_out` and `err` are registered, with no combinational path from inputs.

## Test plan
- Reset, then `mem_write` addr=3 wdata=16'hA5A5 with WAIT_STATES=2 -> `busy` high 3 cycles, `ready` one cycle at T0+3. Then `mem_read` addr=3 -> `rdata`=16'hA5A5 with `ready`.
- WAIT_STATES=0: back-to-back write addr=0 16'h1234, read addr=0 -> each `ready` one cycle after acceptance, `rdata`=16'h1234. No extra wait cycle.
- Write 16'hBEEF to 16'hFF00 -> `io_out`=16'hBEEF on the access edge. Read 16'hFF01 with `io_in`=16'h0C0C -> `rdata`=16'h0C0C.
- Read addr=16'h0040 (DEPTH=16) -> `rdata`=0, `err`=1. Both ops high -> `ready` pulses, `rdata` unchanged, `err` stays 1 until reset.
- Store addr=5 16'h5555, then store addr=5 16'hFFFF with `reset` asserted at T0+1 -> no `ready`, all outputs 0. A later read of addr=5 returns 16'h5555.
- Hold `mem_read` through `ready` -> a second transaction is accepted in the following IDLE cycle. `addr`/`wdata` toggled mid-WAIT do not affect the result.
